// File: rtl/sram_arbiter.sv
// Three-port arbiter for the shared 1M x 16 audio SRAM.
// Playback reads win by default; the recorder is forced through after
// STARVE_MAX consecutive losses to playback; the monitor gets leftover slots.
// All SRAM pins and handshake outputs are registered from the next state.
module sram_arbiter #(
  parameter int unsigned ADDR_W     = 20,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned RD_WAIT    = 1,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_play_req,
  input  logic [ADDR_W-1:0] i_play_addr,
  output logic [DATA_W-1:0] o_play_data,
  output logic              o_play_valid,
  input  logic              i_rec_req,
  input  logic [ADDR_W-1:0] i_rec_addr,
  input  logic [DATA_W-1:0] i_rec_data,
  output logic              o_rec_ack,
  input  logic              i_mon_req,
  input  logic [ADDR_W-1:0] i_mon_addr,
  output logic [DATA_W-1:0] o_mon_data,
  output logic              o_mon_valid,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [DATA_W-1:0] o_sram_dq,
  output logic              o_sram_dq_oe,
  input  logic [DATA_W-1:0] i_sram_dq,
  output logic              o_sram_ce_n,
  output logic              o_sram_oe_n,
  output logic              o_sram_we_n,
  output logic              o_sram_lb_n,
  output logic              o_sram_ub_n
);

  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] RD_WAIT_CNT = CNT_W'(RD_WAIT);
  localparam logic [CNT_W-1:0] STARVE_CNT  = CNT_W'(STARVE_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RD_CAP,
    S_RD_DONE,
    S_WR,
    S_WR_END
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic             rd_play_q, rd_play_d;
  logic             grant_play, grant_rec, grant_mon;
  logic             ce_n_d, oe_n_d, we_n_d, dq_oe_d;
  logic             play_valid_d, mon_valid_d, rec_ack_d;

  // State, read-wait counter, starve counter and read-owner registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      starve_q  <= '0;
      rd_play_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      starve_q  <= starve_d;
      rd_play_q <= rd_play_d;
    end
  end

  // Arbitration, sequencing and next values of the registered pins
  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    starve_d     = starve_q;
    rd_play_d    = rd_play_q;
    grant_play   = 1'b0;
    grant_rec    = 1'b0;
    grant_mon    = 1'b0;
    ce_n_d       = 1'b1;
    oe_n_d       = 1'b1;
    we_n_d       = 1'b1;
    dq_oe_d      = 1'b0;
    play_valid_d = 1'b0;
    mon_valid_d  = 1'b0;
    rec_ack_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_rec_req && (starve_q == STARVE_CNT)) begin
          grant_rec = 1'b1;
        end else if (i_play_req) begin
          grant_play = 1'b1;
        end else if (i_rec_req) begin
          grant_rec = 1'b1;
        end else if (i_mon_req) begin
          grant_mon = 1'b1;
        end

        if (!i_rec_req) begin
          starve_d = '0;
        end

        if (grant_play) begin
          state_d   = S_RD;
          wait_d    = '0;
          rd_play_d = 1'b1;
          // Cannot pass STARVE_CNT: at STARVE_CNT a pending recorder wins
          if (i_rec_req) begin
            starve_d = starve_q + CNT_W'(1);
          end
        end else if (grant_rec) begin
          state_d  = S_WR;
          starve_d = '0;
        end else if (grant_mon) begin
          state_d   = S_RD;
          wait_d    = '0;
          rd_play_d = 1'b0;
        end
      end
      S_RD: begin
        if (wait_q == RD_WAIT_CNT) begin
          state_d = S_RD_CAP;
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end
      S_RD_CAP:  state_d = S_RD_DONE;
      S_RD_DONE: state_d = S_IDLE;
      S_WR:      state_d = S_WR_END;
      S_WR_END:  state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    case (state_d)
      S_RD, S_RD_CAP: begin
        ce_n_d = 1'b0;
        oe_n_d = 1'b0;
      end
      S_RD_DONE: begin
        play_valid_d = rd_play_q;
        mon_valid_d  = !rd_play_q;
      end
      S_WR: begin
        ce_n_d  = 1'b0;
        we_n_d  = 1'b0;
        dq_oe_d = 1'b1;
      end
      S_WR_END: begin
        ce_n_d    = 1'b0;
        dq_oe_d   = 1'b1;
        rec_ack_d = 1'b1;
      end
      default: begin
        ce_n_d = 1'b1;
      end
    endcase
  end

  // SRAM pins and handshake pulses, registered from the next state
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_sram_ce_n  <= 1'b1;
      o_sram_oe_n  <= 1'b1;
      o_sram_we_n  <= 1'b1;
      o_sram_lb_n  <= 1'b1;
      o_sram_ub_n  <= 1'b1;
      o_sram_dq_oe <= 1'b0;
      o_play_valid <= 1'b0;
      o_mon_valid  <= 1'b0;
      o_rec_ack    <= 1'b0;
    end else begin
      o_sram_ce_n  <= ce_n_d;
      o_sram_oe_n  <= oe_n_d;
      o_sram_we_n  <= we_n_d;
      o_sram_lb_n  <= ce_n_d;
      o_sram_ub_n  <= ce_n_d;
      o_sram_dq_oe <= dq_oe_d;
      o_play_valid <= play_valid_d;
      o_mon_valid  <= mon_valid_d;
      o_rec_ack    <= rec_ack_d;
    end
  end

  // Address and write data are latched only when leaving IDLE with a grant
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_sram_addr <= '0;
      o_sram_dq   <= '0;
    end else if (grant_play) begin
      o_sram_addr <= i_play_addr;
    end else if (grant_rec) begin
      o_sram_addr <= i_rec_addr;
      o_sram_dq   <= i_rec_data;
    end else if (grant_mon) begin
      o_sram_addr <= i_mon_addr;
    end
  end

  // Read data capture at the end of RD_CAP; each port holds its last word
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_play_data <= '0;
      o_mon_data  <= '0;
    end else if (state_q == S_RD_CAP) begin
      if (rd_play_q) begin
        o_play_data <= i_sram_dq;
      end else begin
        o_mon_data <= i_sram_dq;
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: behavioural SRAM, completion scoreboard, pin checks.
module tb_sram_arbiter;

  localparam int unsigned ADDR_W     = 20;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned RD_WAIT    = 1;
  localparam int unsigned STARVE_MAX = 3;

  localparam logic [1:0] K_PLAY = 2'd0;
  localparam logic [1:0] K_REC  = 2'd1;
  localparam logic [1:0] K_MON  = 2'd2;

  typedef struct packed {
    logic [1:0]        kind;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              play_req, rec_req, mon_req;
  logic [ADDR_W-1:0] play_addr, rec_addr, mon_addr;
  logic [DATA_W-1:0] rec_data;
  logic [DATA_W-1:0] play_data, mon_data;
  logic              play_valid, rec_ack, mon_valid;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_dq, sram_rd;
  logic              sram_dq_oe, ce_n, oe_n, we_n, lb_n, ub_n;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];
  logic [DATA_W-1:0] wr_mem [int];

  sram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_WAIT(RD_WAIT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_play_req(play_req), .i_play_addr(play_addr),
    .o_play_data(play_data), .o_play_valid(play_valid),
    .i_rec_req(rec_req), .i_rec_addr(rec_addr), .i_rec_data(rec_data),
    .o_rec_ack(rec_ack),
    .i_mon_req(mon_req), .i_mon_addr(mon_addr),
    .o_mon_data(mon_data), .o_mon_valid(mon_valid),
    .o_sram_addr(sram_addr), .o_sram_dq(sram_dq), .o_sram_dq_oe(sram_dq_oe),
    .i_sram_dq(sram_rd),
    .o_sram_ce_n(ce_n), .o_sram_oe_n(oe_n), .o_sram_we_n(we_n),
    .o_sram_lb_n(lb_n), .o_sram_ub_n(ub_n)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Unwritten words read as a fixed pattern; 0x00010 is preloaded with 0x1234
  function automatic logic [DATA_W-1:0] mem_rd(input logic [ADDR_W-1:0] a);
    if (wr_mem.exists(int'(a))) return wr_mem[int'(a)];
    if (a == 20'h00010) return 16'h1234;
    return 16'hA000 | 16'(a[7:0]);
  endfunction

  // SRAM write on the edge closing a WE-low cycle
  always @(posedge clk) begin
    if (!ce_n && !we_n) wr_mem[int'(sram_addr)] = sram_dq;
  end

  // SRAM read data presented while CE/OE are low, settled before the capture edge
  always @(negedge clk) begin
    sram_rd <= (!ce_n && !oe_n) ? mem_rd(sram_addr) : 16'h0000;
  end

  exp_t        mon_e;
  int          mon_ev;
  logic [1:0]  mon_kind;
  logic [15:0] mon_dat;

  // Completion scoreboard and pin invariants, sampled on the falling edge
  always @(negedge clk) begin
    check_eq("oe_we_overlap", 32'(!oe_n && !we_n), 32'd0);
    check_eq("dq_oe_while_oe", 32'(sram_dq_oe && !oe_n), 32'd0);
    mon_ev = int'(play_valid) + int'(rec_ack) + int'(mon_valid);
    if (mon_ev != 0) begin
      check_eq("one_completion", 32'(mon_ev), 32'd1);
      mon_kind = play_valid ? K_PLAY : (rec_ack ? K_REC : K_MON);
      mon_dat  = play_valid ? play_data : (rec_ack ? sram_dq : mon_data);
      if (sb.size() == 0) begin
        check_eq("unexpected_completion", 32'(mon_kind), 32'hFF);
      end else begin
        mon_e = sb.pop_front();
        check_eq("sb_kind", 32'(mon_kind), 32'(mon_e.kind));
        check_eq("sb_data", 32'(mon_dat), 32'(mon_e.data));
      end
    end
  end

  function automatic exp_t mk(input logic [1:0] k, input logic [DATA_W-1:0] d);
    exp_t e;
    e.kind = k;
    e.data = d;
    return e;
  endfunction

  int oe_cnt, we_cnt, dq_cnt, dq_bad, vcyc, other, acks, pv, ra;

  initial begin
    rst_n = 1'b0;
    play_req = 1'b0; rec_req = 1'b0; mon_req = 1'b0;
    play_addr = '0; rec_addr = '0; mon_addr = '0; rec_data = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_strobes", 32'({ce_n, oe_n, we_n, lb_n, ub_n}), 32'h1F);
    check_eq("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
    check_eq("rst_addr", 32'(sram_addr), 32'd0);
    check_eq("rst_dq", 32'(sram_dq), 32'd0);
    check_eq("rst_data", 32'({play_data, mon_data}), 32'd0);
    check_eq("rst_pulses", 32'({play_valid, rec_ack, mon_valid}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single playback read; address change mid-access must be ignored
    play_addr = 20'h00010; play_req = 1'b1;
    sb.push_back(mk(K_PLAY, 16'h1234));
    oe_cnt = 0; vcyc = 0; other = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (n == 1) play_addr = 20'h00099;
      if (!oe_n) oe_cnt++;
      if (rec_ack || mon_valid) other++;
      if (play_valid && vcyc == 0) begin vcyc = n; play_req = 1'b0; end
    end
    check_eq("play_oe_cycles", 32'(oe_cnt), 32'(RD_WAIT + 2));
    check_eq("play_valid_lat", 32'(vcyc), 32'(RD_WAIT + 3));
    check_eq("play_no_other", 32'(other), 32'd0);

    // Recorder write
    rec_addr = 20'h00020; rec_data = 16'hBEEF; rec_req = 1'b1;
    sb.push_back(mk(K_REC, 16'hBEEF));
    we_cnt = 0; dq_cnt = 0; dq_bad = 0; vcyc = 0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (n == 1) rec_data = 16'h0BAD;
      if (!we_n) we_cnt++;
      if (sram_dq_oe) begin
        dq_cnt++;
        if (sram_dq != 16'hBEEF) dq_bad++;
      end
      if (rec_ack && vcyc == 0) begin vcyc = n; rec_req = 1'b0; end
    end
    check_eq("wr_we_cycles", 32'(we_cnt), 32'd1);
    check_eq("wr_dq_oe_cycles", 32'(dq_cnt), 32'd2);
    check_eq("wr_dq_value", 32'(dq_bad), 32'd0);
    check_eq("wr_ack_lat", 32'(vcyc), 32'd2);

    // Monitor reads back the written word
    mon_addr = 20'h00020; mon_req = 1'b1;
    sb.push_back(mk(K_MON, 16'hBEEF));
    vcyc = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (mon_valid && vcyc == 0) begin vcyc = n; mon_req = 1'b0; end
    end
    check_eq("mon_valid_lat", 32'(vcyc), 32'(RD_WAIT + 3));

    // All three held: play x3 then forced rec, twice; monitor starves
    play_addr = 20'h00030; rec_addr = 20'h00040; rec_data = 16'h5555; mon_addr = 20'h00050;
    for (int r = 0; r < 2; r++) begin
      for (int p = 0; p < int'(STARVE_MAX); p++) sb.push_back(mk(K_PLAY, 16'hA030));
      sb.push_back(mk(K_REC, 16'h5555));
    end
    play_req = 1'b1; rec_req = 1'b1; mon_req = 1'b1;
    acks = 0;
    for (int n = 0; n < 200 && acks < 2; n++) begin
      @(negedge clk);
      if (rec_ack) acks++;
    end
    play_req = 1'b0; rec_req = 1'b0; mon_req = 1'b0;
    check_eq("contend_rec_acks", 32'(acks), 32'd2);
    repeat (3) @(negedge clk);

    // Play drops after one grant: rec follows at once; rec grant clears the
    // starve count, so with both re-held three plays precede the next rec
    play_addr = 20'h00031; rec_addr = 20'h00041; rec_data = 16'h6666;
    sb.push_back(mk(K_PLAY, 16'hA031));
    sb.push_back(mk(K_REC, 16'h6666));
    for (int p = 0; p < int'(STARVE_MAX); p++) sb.push_back(mk(K_PLAY, 16'hA031));
    sb.push_back(mk(K_REC, 16'h6666));
    play_req = 1'b1; rec_req = 1'b1;
    acks = 0; pv = 0; ra = 0;
    for (int n = 1; n <= 200 && acks < 2; n++) begin
      @(negedge clk);
      if (play_valid && pv == 0) begin pv = n; play_req = 1'b0; end
      if (rec_ack) begin
        acks++;
        if (acks == 1) begin ra = n; play_req = 1'b1; end
      end
    end
    play_req = 1'b0; rec_req = 1'b0;
    check_eq("rec_after_play_gap", 32'(ra - pv), 32'd3);
    check_eq("starve_clear_acks", 32'(acks), 32'd2);
    repeat (3) @(negedge clk);

    // Reset during RD_CAP aborts the read with no valid
    play_addr = 20'h00011; play_req = 1'b1;
    for (int n = 1; n <= int'(RD_WAIT) + 2; n++) @(negedge clk);
    check_eq("rdcap_oe_low", 32'(oe_n), 32'd0);
    rst_n = 1'b0;
    #1;
    check_eq("abort_strobes", 32'({ce_n, oe_n, we_n, lb_n, ub_n}), 32'h1F);
    check_eq("abort_dq_oe", 32'(sram_dq_oe), 32'd0);
    check_eq("abort_play_data", 32'(play_data), 32'd0);
    play_req = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Fresh read after reset release
    play_addr = 20'h00012; play_req = 1'b1;
    sb.push_back(mk(K_PLAY, 16'hA012));
    vcyc = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (play_valid && vcyc == 0) begin vcyc = n; play_req = 1'b0; end
    end
    check_eq("post_rst_valid_lat", 32'(vcyc), 32'(RD_WAIT + 3));

    repeat (2) @(negedge clk);
    check_eq("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
